// File: rtl/axis_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin AXI Stream arbiter.
package axis_rr_arbiter_pkg;

  localparam int unsigned DEFAULT_N           = 2;
  localparam int unsigned DEFAULT_MAX_BURST   = 4;
  localparam int unsigned DEFAULT_TDATA_WIDTH = 8;

  // Fold an index in 0..2n-1 back into 0..n-1 (one subtraction suffices).
  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
    if (idx >= n) begin
      return idx - n;
    end else begin
      return idx;
    end
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: keeps a locked holder while it requests,
// otherwise finds the first requester after base_i, wrapping back to base_i.
module rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N,
  localparam int unsigned ID_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]        req_i,
  input  logic [ID_WIDTH-1:0] base_i,
  input  logic                lock_i,
  output logic [ID_WIDTH-1:0] sel_o,
  output logic                any_o
);

  logic [2*N-1:0]      dbl_s;
  logic [N-1:0]        rot_s;
  logic [ID_WIDTH:0]   shamt_s;
  logic [ID_WIDTH-1:0] off_s;
  logic [ID_WIDTH-1:0] scan_s;

  // Rotate the doubled request vector so bit 0 is the port right after base_i.
  always_comb begin
    dbl_s   = {req_i, req_i};
    shamt_s = {1'b0, base_i} + (ID_WIDTH + 1)'(1);
    rot_s   = dbl_s[shamt_s +: N];
  end

  // Lowest set bit of the rotated vector is the nearest requester in RR order.
  always_comb begin
    off_s = {ID_WIDTH{1'b0}};
    for (int k = int'(N) - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? ID_WIDTH'(k) : off_s;
    end
    scan_s = ID_WIDTH'(wrap_idx(32'(shamt_s) + 32'(off_s), N));
  end

  // A locked holder that still requests wins outright; otherwise take the scan.
  always_comb begin
    any_o = |req_i;
    if (lock_i && req_i[base_i]) begin
      sel_o = base_i;
    end else begin
      sel_o = scan_s;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI Stream round-robin arbiter with bounded burst lock, a single
// registered output stage and the winning source index alongside each beat.
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int unsigned N           = DEFAULT_N,
  parameter int unsigned MAX_BURST   = DEFAULT_MAX_BURST,
  parameter int unsigned TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
  localparam int unsigned ID_WIDTH   = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               s_tvalid_i,
  input  logic [N*TDATA_WIDTH-1:0]   s_tdata_i,
  output logic [N-1:0]               s_tready_o,
  output logic                       m_tvalid_o,
  output logic [TDATA_WIDTH-1:0]     m_tdata_o,
  input  logic                       m_tready_i,
  output logic [ID_WIDTH-1:0]        m_tid_o,
  input  logic                       invalidate_i
);

  localparam int unsigned         CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(MAX_BURST);
  localparam logic [ID_WIDTH-1:0] GRANT_RST = ID_WIDTH'(N - 1);

  if (N < 2) begin : g_chk_n
    $fatal(1, "axis_rr_arbiter: N must be >= 2");
  end
  if (MAX_BURST < 1) begin : g_chk_burst
    $fatal(1, "axis_rr_arbiter: MAX_BURST must be >= 1");
  end

  logic                   tvalid_q, tvalid_d;
  logic [TDATA_WIDTH-1:0] tdata_q,  tdata_d;
  logic [ID_WIDTH-1:0]    tid_q,    tid_d;
  logic [ID_WIDTH-1:0]    grant_q,  grant_d;
  logic                   lock_q,   lock_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;

  logic                   accept_s;
  logic                   hs_s;
  logic [ID_WIDTH-1:0]    sel_s;
  logic                   any_s;

  rr_pick #(.N(N)) u_pick (
    .req_i  (s_tvalid_i),
    .base_i (grant_q),
    .lock_i (lock_q),
    .sel_o  (sel_s),
    .any_o  (any_s)
  );

  // Output slot is free when empty or draining; a take needs a winner, no flush, no reset.
  always_comb begin
    accept_s = !tvalid_q || m_tready_i;
    hs_s     = accept_s && any_s && !invalidate_i && !rst;
  end

  // Fan tready out to the selected port only, so at most one input handshakes.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      s_tready_o[i] = hs_s && (sel_s == ID_WIDTH'(i));
    end
  end

  // Next state for output register, grant pointer and burst lock.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    grant_d  = grant_q;
    lock_d   = lock_q;
    cnt_d    = cnt_q;
    if (invalidate_i) begin
      tvalid_d = 1'b0;
      lock_d   = 1'b0;
      cnt_d    = {CNT_W{1'b0}};
    end else if (hs_s) begin
      tvalid_d = 1'b1;
      tdata_d  = s_tdata_i[sel_s*TDATA_WIDTH +: TDATA_WIDTH];
      tid_d    = sel_s;
      grant_d  = sel_s;
      if (lock_q && (sel_s == grant_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = CNT_W'(1);
      end
      lock_d = (cnt_d < CNT_MAX);
    end else if (accept_s) begin
      tvalid_d = 1'b0;
      if (lock_q && !s_tvalid_i[grant_q]) begin
        lock_d = 1'b0;
      end else begin
        lock_d = lock_q;
      end
    end else begin
      lock_d = lock_q;
    end
  end

  // State registers with synchronous reset; grant starts at N-1 so port 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= {TDATA_WIDTH{1'b0}};
      tid_q    <= {ID_WIDTH{1'b0}};
      grant_q  <= GRANT_RST;
      lock_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
      grant_q  <= grant_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_tvalid_o = tvalid_q;
  assign m_tdata_o  = tdata_q;
  assign m_tid_o    = tid_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed checks of axis_rr_arbiter on three configurations plus a short
// randomized scoreboard run on the 4-port instance.
module tb_axis_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Instance A: N=3, MAX_BURST=2
  logic [2:0]  a_valid, a_ready;
  logic [23:0] a_data;
  logic        a_mvalid, a_mready, a_inv;
  logic [7:0]  a_mdata;
  logic [1:0]  a_tid;
  // Instance B: N=3, MAX_BURST=1
  logic [2:0]  b_valid, b_ready;
  logic [23:0] b_data;
  logic        b_mvalid, b_mready, b_inv;
  logic [7:0]  b_mdata;
  logic [1:0]  b_tid;
  // Instance C: N=4, MAX_BURST=4
  logic [3:0]  c_valid, c_ready;
  logic [31:0] c_data;
  logic        c_mvalid, c_mready, c_inv;
  logic [7:0]  c_mdata;
  logic [1:0]  c_tid;

  int seq_burst [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
  int seq_drop  [5] = '{0, 0, 1, 2, 2};
  int sent [4];
  int got  [4];
  int wait_cnt [4];
  logic [3:0] acc_prev;
  int src;

  axis_rr_arbiter #(.N(3), .MAX_BURST(2), .TDATA_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .s_tvalid_i(a_valid), .s_tdata_i(a_data), .s_tready_o(a_ready),
    .m_tvalid_o(a_mvalid), .m_tdata_o(a_mdata), .m_tready_i(a_mready), .m_tid_o(a_tid),
    .invalidate_i(a_inv));

  axis_rr_arbiter #(.N(3), .MAX_BURST(1), .TDATA_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .s_tvalid_i(b_valid), .s_tdata_i(b_data), .s_tready_o(b_ready),
    .m_tvalid_o(b_mvalid), .m_tdata_o(b_mdata), .m_tready_i(b_mready), .m_tid_o(b_tid),
    .invalidate_i(b_inv));

  axis_rr_arbiter #(.N(4), .MAX_BURST(4), .TDATA_WIDTH(8)) dut_c (
    .clk(clk), .rst(rst), .s_tvalid_i(c_valid), .s_tdata_i(c_data), .s_tready_o(c_ready),
    .m_tvalid_o(c_mvalid), .m_tdata_o(c_mdata), .m_tready_i(c_mready), .m_tid_o(c_tid),
    .invalidate_i(c_inv));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_all;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 3'b000; a_data = 24'h0; a_mready = 1'b0; a_inv = 1'b0;
    b_valid = 3'b000; b_data = 24'h0; b_mready = 1'b0; b_inv = 1'b0;
    c_valid = 4'b0000; c_data = 32'h0; c_mready = 1'b0; c_inv = 1'b0;

    // ---- Reset and priority order (B: N=3, MAX_BURST=1) ----
    b_valid  = 3'b111;
    b_data   = {8'hC0, 8'hB0, 8'hA0};
    b_mready = 1'b1;
    tick();
    chk("rst_tvalid", 32'(b_mvalid), 32'd0);
    chk("rst_tready", 32'(b_ready), 32'd0);
    chk("rst_tid", 32'(b_tid), 32'd0);
    tick();
    chk("rst_tready2", 32'(b_ready), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("prio_tvalid", 32'(b_mvalid), 32'd1);
      chk("prio_tid", 32'(b_tid), 32'(k % 3));
      chk("prio_data", 32'(b_mdata), 32'(8'hA0 + 8'h10 * (k % 3)));
    end
    b_valid = 3'b000;

    // ---- Burst lock (A: N=3, MAX_BURST=2) ----
    a_valid  = 3'b111;
    a_data   = {8'h03, 8'h02, 8'h01};
    a_mready = 1'b1;
    reset_all();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("burst_tid", 32'(a_tid), 32'(seq_burst[k]));
      chk("burst_data", 32'(a_mdata), 32'(seq_burst[k] + 1));
    end

    // ---- Holder drops valid after its first beat ----
    a_valid = 3'b111;
    reset_all();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("drop_tid", 32'(a_tid), 32'(seq_drop[k]));
      if (k == 2) begin
        a_valid = 3'b101;
      end
    end

    // ---- Invalidate while locked on index 1 ----
    a_valid = 3'b111;
    reset_all();
    tick();
    tick();
    tick();
    chk("inv_pre_tid", 32'(a_tid), 32'd1);
    a_inv    = 1'b1;
    a_mready = 1'b0;
    #1;
    chk("inv_tready", 32'(a_ready), 32'd0);
    tick();
    chk("inv_tvalid", 32'(a_mvalid), 32'd0);
    a_inv    = 1'b0;
    a_mready = 1'b1;
    #1;
    chk("inv_pick", 32'(a_ready), 32'b100);
    tick();
    chk("inv_next_valid", 32'(a_mvalid), 32'd1);
    chk("inv_next_tid", 32'(a_tid), 32'd2);
    chk("inv_next_data", 32'(a_mdata), 32'h03);

    // ---- Backpressure on a held beat ----
    a_valid  = 3'b001;
    a_data   = {8'h00, 8'h00, 8'h11};
    a_mready = 1'b1;
    reset_all();
    tick();
    chk("bp_first", 32'(a_mdata), 32'h11);
    a_mready = 1'b0;
    a_data[7:0] = 8'h22;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 32'(a_mvalid), 32'd1);
      chk("bp_hold_data", 32'(a_mdata), 32'h11);
      chk("bp_hold_tid", 32'(a_tid), 32'd0);
      chk("bp_hold_tready", 32'(a_ready), 32'd0);
    end
    a_mready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_ready), 32'b001);
    tick();
    chk("bp_next_data", 32'(a_mdata), 32'h22);
    a_data[7:0] = 8'h33;
    tick();
    chk("bp_nobubble_valid", 32'(a_mvalid), 32'd1);
    chk("bp_nobubble_data", 32'(a_mdata), 32'h33);
    a_valid = 3'b000;

    // ---- Single requester across burst boundaries (C: N=4, MAX_BURST=4) ----
    c_valid  = 4'b0100;
    c_data   = 32'h0;
    c_data[23:16] = 8'h40;
    c_mready = 1'b1;
    reset_all();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("single_valid", 32'(c_mvalid), 32'd1);
      chk("single_tid", 32'(c_tid), 32'd2);
      chk("single_data", 32'(c_mdata), 32'(8'(8'h40 + k)));
      c_data[23:16] = 8'(8'h41 + k);
    end

    // ---- Random stress with scoreboard (C) ----
    c_valid = 4'b0000;
    reset_all();
    acc_prev = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      got[i] = 0;
      wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 460; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(c_valid[i] && !acc_prev[i])) begin
          c_valid[i] = (cyc < 400) && ($urandom_range(0, 99) < 60);
          c_data[i*8 +: 8] = {i[1:0], sent[i][5:0]};
        end
      end
      c_mready = (cyc >= 400) || ($urandom_range(0, 99) < 70);
      #1;
      chk("onehot_tready", 32'($countones(c_ready) <= 1), 32'd1);
      acc_prev = c_valid & c_ready;
      if (c_mvalid && c_mready) begin
        src = int'(c_tid);
        chk("sb_src", 32'(c_mdata[7:6]), 32'(c_tid));
        chk("sb_order", 32'(c_mdata[5:0]), 32'(got[src] % 64));
        got[src]++;
      end
      for (int i = 0; i < 4; i++) begin
        if (acc_prev[i]) begin
          sent[i]++;
          chk("starvation", 32'(wait_cnt[i] <= 12), 32'd1);
          wait_cnt[i] = 0;
        end else if (c_valid[i]) begin
          if (|acc_prev) begin
            wait_cnt[i]++;
          end
        end else begin
          wait_cnt[i] = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      chk("lossless", 32'(got[i]), 32'(sent[i]));
    end
    chk("drained", 32'(c_mvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin arbiter that merges N AXI Stream subordinate ports into one manager port, with a registered output stage. It shares one downstream resource, such as an `axis_sync_fifo` or a memory request channel, between several requesters. A bounded burst lock keeps a requester granted for up to MAX_BURST consecutive beats. The block also emits the winning source index alongside each output beat.

## Interface
- `N`, 2: number of subordinate ports; must be ≥ 2.
- `MAX_BURST`, 4: maximum consecutive beats granted to one requester before rotation; must be ≥ 1. A value of 1 gives pure per-beat round-robin.
- `ID_WIDTH`, `$clog2(N)` (localparam): width of the source index.
- `TDATA_WIDTH` (localparam): taken from `axis_mif.TDATA_WIDTH`; all `axis_sif[i]` must match (elaboration-time `$fatal`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `axis_sif[N]`  `axis_if.s`  —  requester streams (`tvalid`, `tdata`, `tready`).
- `axis_mif`  `axis_if.m`  —  merged output stream.
- `m_tid`  out  ID_WIDTH  index of the source of the current `axis_mif` beat; valid when `axis_mif.tvalid`.
- `invalidate`  in  1  flush: drops the held output beat and releases any burst lock.

## Operation
- State:
  - `tvalid_q`, `tdata_q`, `tid_q`: output register.
  - `grant_q`: last granted index.
  - `lock_q`: burst in progress.
  - `cnt_q`: beats in the current burst, range 0..MAX_BURST.
- `accept = !tvalid_q || axis_mif.tready`.
- Selection (combinational):
  - If `lock_q && axis_sif[grant_q].tvalid`, then `sel = grant_q`.
  - Otherwise `sel` is the first valid index scanning `grant_q+1, grant_q+2, …` modulo N, ending at `grant_q` itself.
  - If no input is valid, there is no selection.
- `axis_sif[sel].tready = accept && !invalidate`. Every other `tready` is 0. At most one input `tready` is high per cycle.
- On a handshake with `sel`:
  - `tvalid_d = 1`, `tdata_d = axis_sif[sel].tdata`, `tid_d = sel`, `grant_q <= sel`.
  - If `sel == grant_q && lock_q`, then `cnt_d = cnt_q + 1`; otherwise `cnt_d = 1`.
  - `lock_d = (cnt_d < MAX_BURST)`.
- When `accept` is true but there is no handshake:
  - `tvalid_d = 0`.
  - `lock_d = 0` if the locked holder has deasserted `tvalid`, so a dropped holder loses the lock immediately.
  - `grant_q` is unchanged.
- When `tvalid_q && !axis_mif.tready` (output stalled): all registers hold; the lock does not age.
- `invalidate` (priority below `rst`):
  - `tvalid_q <= 0`, `lock_q <= 0`, `cnt_q <= 0`.
  - `grant_q` is kept.
  - No input handshake occurs in that cycle.
- Reset values:
  - `tvalid_q = 0`, `tdata_q = 0`, `tid_q = 0`.
  - `grant_q = N-1`, so index 0 has first priority.
  - `lock_q = 0`, `cnt_q = 0`.
- Resulting output values during reset: `axis_mif.tvalid = 0`, `m_tid = 0`, all `axis_sif[i].tready = 0`.
- The registers are driven straight to the outputs: `axis_mif.tvalid = tvalid_q`, `axis_mif.tdata = tdata_q`, `m_tid = tid_q`.

## Timing
- Latency: an input handshake in cycle t appears on `axis_mif` in cycle t+1.
- Throughput: 1 beat/cycle sustained, including back-to-back beats from different sources.
- The combinational path `axis_mif.tready` → `axis_sif[sel].tready` is intentional (single-entry pipeline stage). Callers needing a cut insert an `axis_sync_fifo` downstream.
- Once `axis_mif.tvalid` is high it stays high, with `tdata`/`m_tid` stable, until the handshake or `invalidate`.
- A requester held continuously valid is granted within `(N-1)*MAX_BURST` accepted beats of other traffic (starvation bound).

## Structure
- No package typedefs are required; `ID_WIDTH` is a local localparam.
- One sub-module, `rr_pick`: purely combinational.
  - Parameter: `N`.
  - Inputs: request vector [N], base index `grant_q`, `lock_q`.
  - Outputs: `sel` [ID_WIDTH] and `any`.
  - Implementation: double-width request vector rotation; `sel` is reduced modulo N so non-power-of-2 N works.
- The top level holds the output register, burst counter, lock and the `tready` fan-out.

## Test plan
- Reset and priority order (N=3, MAX_BURST=1): all inputs valid with data 0xA0/0xB0/0xC0, `axis_mif.tready=1`.
  - During reset: `tvalid`=0 and all `tready`=0.
  - Afterwards, output beats A0,B0,C0,A0… with `m_tid` 0,1,2,0, one per cycle, starting the cycle after the first accept.
- Burst lock (N=3, MAX_BURST=2): all valid.
  - `m_tid` sequence 0,0,1,1,2,2,0,0.
  - When input 1 drops `tvalid` after its first beat, the sequence is 0,0,1,2,2.
- Backpressure: `axis_mif.tready=0` for 5 cycles while beat 0x11 is held.
  - `tdata`/`m_tid` stay stable and every `sif.tready`=0.
  - On release the next beat follows with no bubble.
- Single requester: only input 2 is valid, streaming 8 beats with MAX_BURST=4.
  - All 8 beats pass at 1/cycle with `m_tid`=2 and no gap at the burst boundary.
- Invalidate: pulse `invalidate` while `tvalid_q`=1 and the lock is held on index 1.
  - Next cycle `axis_mif.tvalid`=0 and the held beat is never delivered.
  - The following grant goes to index 2, not 1.
- Random stress (N=4): random `tvalid`/`tready`.
  - Scoreboard checks per-source order and lossless delivery.
  - Check at most one `sif.tready` per cycle.
  - Check the starvation bound.
